// File: rtl/ip_codma_task_sequencer.sv
// CoDMA control-side initiator: queues task/status pointer pairs and
// launches them one at a time, tracking completion, timeout and abort.
module ip_codma_task_sequencer #(
  parameter int QUEUE_DEPTH   = 4,
  parameter int START_TIMEOUT = 64,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           enable_i,
  input  logic                           push_i,
  input  logic [31:0]                    push_task_ptr_i,
  input  logic [31:0]                    push_status_ptr_i,
  output logic                           full_o,
  output logic [$clog2(QUEUE_DEPTH):0]   level_o,
  input  logic                           abort_i,
  output logic                           start_o,
  output logic                           stop_o,
  output logic [31:0]                    task_pointer_o,
  output logic [31:0]                    status_pointer_o,
  input  logic                           busy_i,
  input  logic                           irq_i,
  output logic                           idle_o,
  output logic                           done_o,
  output logic                           irq_seen_o,
  output logic [CNT_WIDTH-1:0]           done_count_o,
  output logic                           timeout_o,
  output logic                           aborted_o
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    RUN,
    ABORT
  } state_t;

  state_t state, state_nxt;

  logic [31:0]    mem_task [QUEUE_DEPTH];
  logic [31:0]    mem_stat [QUEUE_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [LW-1:0]  cnt;
  logic [TW-1:0]  tcnt;
  logic           irq_flag;
  logic           start_q, stop_q;
  logic           done_q, irq_seen_q, timeout_q, aborted_q;
  logic [CNT_WIDTH-1:0] done_cnt;
  logic [31:0]    task_q, stat_q;

  logic empty, full;
  logic launch, flush, push_ok;
  logic tmo_hit;
  logic done_nxt, timeout_nxt;

  assign empty   = (cnt == '0);
  assign full    = (cnt == LW'(QUEUE_DEPTH));
  assign tmo_hit = (tcnt == TW'(START_TIMEOUT - 1));

  assign launch  = (state == IDLE) && enable_i && !empty && !abort_i;
  // Flush happens on an idle abort or once CoDMA has gone quiet after stop
  assign flush   = ((state == IDLE) && abort_i) ||
                   ((state == ABORT) && !busy_i);
  assign push_ok = push_i && !full && !flush;

  always_comb begin
    state_nxt   = state;
    done_nxt    = 1'b0;
    timeout_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (launch) state_nxt = LAUNCH;
      end
      LAUNCH: begin
        if (abort_i) begin
          state_nxt = ABORT;
        end else if (busy_i) begin
          state_nxt = RUN;
        end else if (tmo_hit) begin
          state_nxt   = IDLE;
          timeout_nxt = 1'b1;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_nxt = ABORT;
        end else if (!busy_i) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      ABORT: begin
        if (!busy_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state      <= IDLE;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      tcnt       <= '0;
      irq_flag   <= 1'b0;
      done_q     <= 1'b0;
      irq_seen_q <= 1'b0;
      timeout_q  <= 1'b0;
      aborted_q  <= 1'b0;
      done_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      start_q    <= (state_nxt == LAUNCH);
      stop_q     <= (state_nxt == ABORT);
      tcnt       <= (state == LAUNCH) ? tcnt + TW'(1) : '0;
      done_q     <= done_nxt;
      irq_seen_q <= done_nxt && (irq_flag || irq_i);
      timeout_q  <= timeout_nxt;
      aborted_q  <= flush;
      if (done_nxt) done_cnt <= done_cnt + CNT_WIDTH'(1);
      if ((state == RUN) && (state_nxt == RUN)) begin
        if (irq_i) irq_flag <= 1'b1;
      end else begin
        irq_flag <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_task[wr_ptr] <= push_task_ptr_i;
      mem_stat[wr_ptr] <= push_status_ptr_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (launch)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push_ok, launch})
        2'b10:   cnt <= cnt + LW'(1);
        2'b01:   cnt <= cnt - LW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Pointers are captured at pop and held until the next launch
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      task_q <= '0;
      stat_q <= '0;
    end else if (launch) begin
      task_q <= mem_task[rd_ptr];
      stat_q <= mem_stat[rd_ptr];
    end
  end

  assign full_o           = full;
  assign level_o          = cnt;
  assign start_o          = start_q;
  assign stop_o           = stop_q;
  assign task_pointer_o   = task_q;
  assign status_pointer_o = stat_q;
  assign idle_o           = (state == IDLE) && empty;
  assign done_o           = done_q;
  assign irq_seen_o       = irq_seen_q;
  assign done_count_o     = done_cnt;
  assign timeout_o        = timeout_q;
  assign aborted_o        = aborted_q;

endmodule

// File: tb/tb_ip_codma_task_sequencer.sv
// Bench for ip_codma_task_sequencer: a CoDMA responder driven from the
// main thread, checked against a queue-based model of the host FIFO.
module tb_ip_codma_task_sequencer;

  localparam int QD  = 4;
  localparam int TMO = 64;
  localparam int CW  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable, push, abort, busy, irq;
  logic [31:0]   push_tp, push_sp;
  logic          full, start, stop, idle, done, irq_seen, timeout, aborted;
  logic [2:0]    level;
  logic [31:0]   task_ptr, stat_ptr;
  logic [CW-1:0] done_count;

  int errors = 0;
  int checks = 0;

  logic [31:0] q_tp[$];
  logic [31:0] q_sp[$];
  int model_cnt = 0;

  ip_codma_task_sequencer #(
    .QUEUE_DEPTH(QD),
    .START_TIMEOUT(TMO),
    .CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk),
    .reset_i(rst),
    .enable_i(enable),
    .push_i(push),
    .push_task_ptr_i(push_tp),
    .push_status_ptr_i(push_sp),
    .full_o(full),
    .level_o(level),
    .abort_i(abort),
    .start_o(start),
    .stop_o(stop),
    .task_pointer_o(task_ptr),
    .status_pointer_o(stat_ptr),
    .busy_i(busy),
    .irq_i(irq),
    .idle_o(idle),
    .done_o(done),
    .irq_seen_o(irq_seen),
    .done_count_o(done_count),
    .timeout_o(timeout),
    .aborted_o(aborted)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_push(logic [31:0] tp, logic [31:0] sp);
    push    = 1'b1;
    push_tp = tp;
    push_sp = sp;
    tick();
    push = 1'b0;
    if (q_tp.size() < QD) begin
      q_tp.push_back(tp);
      q_sp.push_back(sp);
    end
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (start) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) chk("start_seen", 0, 1);
  endtask

  task automatic check_launch(output logic [31:0] tp);
    tp = q_tp[0];
    chk("task_ptr", task_ptr, q_tp[0]);
    chk("status_ptr", stat_ptr, q_sp[0]);
    void'(q_tp.pop_front());
    void'(q_sp.pop_front());
  endtask

  task automatic run_one(int dly, int hold, bit with_irq);
    bit ok;
    int n;
    logic [31:0] tp;
    n = 0;
    wait_start(ok);
    if (ok) begin
      check_launch(tp);
      for (int c = 0; c <= dly; c++) begin
        if (c > 0) tick();
        if (start) n++;
      end
      busy = 1'b1;
      for (int i = 0; i < hold; i++) begin
        tick();
        irq = with_irq && (i == 0);
        if (i == 0) chk("start_drop", start, 0);
      end
      chk("ptr_stable", task_ptr, tp);
      irq  = 1'b0;
      busy = 1'b0;
      tick();
      model_cnt = (model_cnt + 1) % (1 << CW);
      chk("start_len", n, dly + 1);
      chk("done", done, 1);
      chk("irq_seen", irq_seen, with_irq);
      chk("count", done_count, model_cnt);
      chk("dwell", start, 0);
      tick();
      chk("done_pulse", done, 0);
    end
  endtask

  task automatic run_timeout();
    bit ok;
    int n;
    logic [31:0] tp;
    n = 0;
    wait_start(ok);
    if (ok) begin
      check_launch(tp);
      for (int i = 0; i < 200; i++) begin
        if (!start) break;
        n++;
        tick();
      end
      chk("tmo_len", n, TMO);
      chk("timeout", timeout, 1);
      chk("tmo_count", done_count, model_cnt);
      tick();
      chk("tmo_pulse", timeout, 0);
    end
  endtask

  initial begin
    bit ok;
    int n;
    int k;
    logic [31:0] tp;
    rst = 1'b1;
    enable = 1'b0;
    push = 1'b0;
    abort = 1'b0;
    busy = 1'b0;
    irq = 1'b0;
    push_tp = '0;
    push_sp = '0;
    tick();
    tick();
    chk("rst_idle", idle, 1);
    chk("rst_start", start, 0);
    chk("rst_stop", stop, 0);
    chk("rst_level", level, 0);
    chk("rst_full", full, 0);
    chk("rst_count", done_count, 0);
    chk("rst_tptr", task_ptr, 0);
    rst = 1'b0;
    tick();

    // single task with the nominal CoDMA timing
    do_push(32'h40, 32'h100);
    chk("level1", level, 1);
    enable = 1'b1;
    run_one(3, 10, 1'b0);
    chk("idle_after", idle, 1);

    // fill past capacity, then drain in order
    enable = 1'b0;
    for (int i = 0; i < 5; i++) do_push($urandom, $urandom);
    chk("full", full, 1);
    chk("level_full", level, q_tp.size());
    enable = 1'b1;
    for (int i = 0; i < 4; i++)
      run_one($urandom_range(1, 6), $urandom_range(2, 12), 1'b0);
    chk("drained", level, 0);

    // launch timeout, next entry still launches
    enable = 1'b0;
    do_push($urandom, $urandom);
    do_push($urandom, $urandom);
    enable = 1'b1;
    run_timeout();
    run_one($urandom_range(1, 6), $urandom_range(2, 12), 1'b0);

    // abort during RUN with 3 queued
    enable = 1'b0;
    for (int i = 0; i < 3; i++) do_push($urandom, $urandom);
    enable = 1'b1;
    wait_start(ok);
    if (ok) begin
      check_launch(tp);
      tick();
      busy = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n = 0;
      for (int c = 0; c < 5; c++) begin
        if (stop) n++;
        tick();
      end
      if (stop) n++;
      busy = 1'b0;
      tick();
      q_tp.delete();
      q_sp.delete();
      chk("stop_len", n, 6);
      chk("stop_drop", stop, 0);
      chk("aborted", aborted, 1);
      chk("abort_level", level, 0);
      chk("abort_nodone", done, 0);
      chk("abort_count", done_count, model_cnt);
      tick();
      chk("aborted_pulse", aborted, 0);
    end

    // abort in IDLE, with a push in the same cycle
    enable = 1'b0;
    do_push($urandom, $urandom);
    do_push($urandom, $urandom);
    abort = 1'b1;
    push = 1'b1;
    tick();
    abort = 1'b0;
    push = 1'b0;
    q_tp.delete();
    q_sp.delete();
    chk("idle_abort", aborted, 1);
    chk("idle_abort_lvl", level, 0);

    // irq on first task only
    do_push($urandom, $urandom);
    do_push($urandom, $urandom);
    enable = 1'b1;
    run_one($urandom_range(1, 6), $urandom_range(2, 12), 1'b1);
    run_one($urandom_range(1, 6), $urandom_range(2, 12), 1'b0);

    // randomized bursts
    for (int it = 0; it < 6; it++) begin
      enable = 1'b0;
      k = $urandom_range(1, 6);
      for (int i = 0; i < k; i++) do_push($urandom, $urandom);
      chk("rnd_level", level, q_tp.size());
      chk("rnd_full", full, q_tp.size() == QD);
      enable = 1'b1;
      while (q_tp.size() > 0)
        run_one($urandom_range(1, 8), $urandom_range(2, 10),
                1'($urandom_range(0, 1)));
    end

    // reset in the middle of a running task
    enable = 1'b0;
    do_push($urandom, $urandom);
    enable = 1'b1;
    wait_start(ok);
    if (ok) begin
      check_launch(tp);
      busy = 1'b1;
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk("mid_idle", idle, 1);
      chk("mid_start", start, 0);
      chk("mid_count", done_count, 0);
      chk("mid_tptr", task_ptr, 0);
      chk("mid_level", level, 0);
      busy = 1'b0;
      enable = 1'b0;
      tick();
      rst = 1'b0;
      model_cnt = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ip_codma_task_sequencer.md
Name: ip_codma_task_sequencer

Overview:
Control-side initiator for ip_codma_top: the block that drives the CoDMA control interface (start/stop/task_pointer/status_pointer) and consumes busy/irq. It queues task/status pointer pairs pushed by a host in a FIFO and launches them one at a time. It tracks each launch to completion, and reports completions, timeouts and aborts. It sits between the host/register layer and ip_codma_top, replacing hand-driven start pulses.

Parameters:
QUEUE_DEPTH, 4, number of pointer-pair entries in the task FIFO (power of 2, >=2)
START_TIMEOUT, 64, cycles start_o may be held without busy_i rising before a launch error
CNT_WIDTH, 16, width of the completion counter

Ports:
clk_i  in  1  clock, all logic on rising edge
reset_i  in  1  asynchronous, active-high reset
enable_i  in  1  allows launching queued tasks; queue still accepts pushes when low
push_i  in  1  push one entry; ignored when full_o=1
push_task_ptr_i  in  32  task descriptor pointer for the pushed entry
push_status_ptr_i  in  32  status pointer for the pushed entry
full_o  out  1  FIFO full
level_o  out  $clog2(QUEUE_DEPTH)+1  FIFO occupancy
abort_i  in  1  abort current task and flush queue
start_o  out  1  to CoDMA start_i
stop_o  out  1  to CoDMA stop_i
task_pointer_o  out  32  to CoDMA task_pointer_i
status_pointer_o  out  32  to CoDMA status_pointer_i
busy_i  in  1  from CoDMA busy_o
irq_i  in  1  from CoDMA irq_o
idle_o  out  1  state IDLE and FIFO empty
done_o  out  1  one-cycle pulse per completed task
irq_seen_o  out  1  with done_o: irq_i was seen during that task
done_count_o  out  CNT_WIDTH  completed tasks, wraps modulo 2^CNT_WIDTH
timeout_o  out  1  one-cycle pulse on launch timeout
aborted_o  out  1  one-cycle pulse when abort completes

Behaviour:
- Reset: all outputs 0 except idle_o=1. FIFO is emptied, state is IDLE, counters are cleared.
- FIFO: synchronous, first-word-fall-through internally. Pointers wrap at QUEUE_DEPTH.
- A push while full is dropped, with no other effect.
- Push and pop in the same cycle: allowed when not full. Level is unchanged.
- A push at level QUEUE_DEPTH-1 sets full_o on the next cycle.
- States: IDLE, LAUNCH, RUN, ABORT.
- IDLE: if enable_i=1, FIFO non-empty and abort_i=0, pop the head. task_pointer_o/status_pointer_o are registered from it, and the next state is LAUNCH. The pointers are stable for the whole of LAUNCH and RUN, and hold their last value afterwards.
- LAUNCH: start_o=1 (registered, first asserted the cycle after the pop). Timeout counter increments each cycle.
  - busy_i=1 -> RUN. start_o drops the next cycle.
  - Counter reaches START_TIMEOUT with busy_i=0 -> timeout_o pulse, start_o drops, return to IDLE. The task is discarded.
- RUN: irq_i=1 in any cycle sets a per-task irq flag. When busy_i=0, done_o pulses for 1 cycle, irq_seen_o=flag in that same cycle, and done_count_o increments. The flag clears and the state returns to IDLE.
- Minimum IDLE dwell between tasks is 1 cycle, so back-to-back tasks give start_o low for at least 1 cycle.
- abort_i in LAUNCH or RUN (highest priority) -> ABORT: start_o=0, stop_o=1.
  - stop_o stays high until busy_i=0 is sampled. Then stop_o drops, the FIFO flushes, aborted_o pulses, and the state returns to IDLE.
  - No done_o and no count increment for an aborted task.
- abort_i in IDLE: flush FIFO, pulse aborted_o next cycle.
- A push in the same cycle as a flush is dropped.
- enable_i low only gates new launches from IDLE; an in-flight task continues.
- busy_i falling during LAUNCH before it ever rose is not a completion; only a busy_i high sample enters RUN.
- Reset mid-task: immediate return to the reset values. CoDMA is not stopped by this block.

Test Plan:
- Push (0x40,0x100), enable, CoDMA model raises busy 3 cycles after start and holds 10 cycles -> start_o high 4 cycles, task_pointer_o=0x40, status_pointer_o=0x100; done_o pulses once, done_count_o=1, idle_o=1.
- Push 4 entries while enable=0, then a 5th -> full_o=1, level_o=4, 5th dropped. Enable -> four launches in push order, done_count_o=4, start_o low >=1 cycle between tasks.
- Model never raises busy -> timeout_o pulses after 64 cycles of start_o; next queued entry then launches.
- 3 entries queued, abort_i during RUN, model drops busy 5 cycles after stop -> stop_o high until busy low, aborted_o pulse, level_o=0, done_count_o unchanged.
- irq_i pulsed mid-RUN on task 1, absent on task 2 -> irq_seen_o=1 with first done_o, 0 with second.
- done_count_o preset near wrap with CNT_WIDTH=2: run 5 tasks -> count reads 1. Assert reset_i mid-RUN -> outputs at reset values the same cycle.
